// File: rtl/cachelinemem_if.sv
// Cache bus between an I$/D$ controller (master) and a line memory responder (slave).
// Signal names follow the cache-side bus naming.
interface cachelinemem_if #(
    parameter int PA_BITS = 34,
    parameter int LINELEN = 512,
    parameter int BEATLEN = 64,
    parameter int LOGBWPL = 3
);
    logic [1:0]         CacheBusRW;
    logic [PA_BITS-1:0] CacheBusAdr;
    logic [BEATLEN-1:0] CacheWriteBeat;
    logic [LINELEN-1:0] FetchBuffer;
    logic [LOGBWPL-1:0] BeatCount;
    logic               SelBusBeat;
    logic               CacheBusAck;
    logic               BusBusy;

    modport master (
        output CacheBusRW, CacheBusAdr, CacheWriteBeat,
        input  FetchBuffer, BeatCount, SelBusBeat, CacheBusAck, BusBusy
    );

    modport slave (
        input  CacheBusRW, CacheBusAdr, CacheWriteBeat,
        output FetchBuffer, BeatCount, SelBusBeat, CacheBusAck, BusBusy
    );
endinterface

// File: rtl/cachelinemem.sv
// Tightly-coupled cache-line backing memory: services line fetches and writebacks
// one beat per cycle after a fixed wait latency.
//
// state  | meaning
// IDLE   | waiting for CacheBusRW, latches line index and op
// WAIT   | latency countdown, cancellable by dropping CacheBusRW
// BEAT   | one beat per cycle, committed
// ACK    | one-cycle CacheBusAck, FetchBuffer holds the full line
module cachelinemem #(
    parameter int PA_BITS  = 34,
    parameter int LINELEN  = 512,
    parameter int BEATLEN  = 64,
    parameter int LOGBWPL  = 3,
    parameter int MEMBEATS = 4096,
    parameter int LATENCY  = 2
) (
    input  logic          clk,
    input  logic          reset,
    cachelinemem_if.slave bus
);
    localparam int OFFSET  = $clog2(LINELEN / 8);
    localparam int MEM_AW  = $clog2(MEMBEATS);
    localparam int LINE_AW = MEM_AW - LOGBWPL;
    localparam int WAIT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_ACK} state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [LOGBWPL-1:0]   beat_q, beat_d;
    logic [LINE_AW-1:0]   line_q, line_d;
    logic                 wr_q, wr_d;
    logic [LINELEN-1:0]   fb_q, fb_d;
    logic                 mem_we;
    logic                 ack;
    logic                 sel;
    logic [MEM_AW-1:0]    mem_idx;
    logic [BEATLEN-1:0]   mem_rdata;
    logic [BEATLEN-1:0]   mem [MEMBEATS];
    logic                 addr_unused;

    // Offset bits are ignored and bits above the store depth alias.
    assign addr_unused = ^{bus.CacheBusAdr[PA_BITS-1:OFFSET+LINE_AW], bus.CacheBusAdr[OFFSET-1:0]};

    assign mem_idx   = {line_q, beat_q};
    assign mem_rdata = mem[mem_idx];

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        line_d  = line_q;
        wr_d    = wr_q;
        fb_d    = fb_q;
        mem_we  = 1'b0;
        ack     = 1'b0;
        sel     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.CacheBusRW != 2'b00) begin
                    line_d  = bus.CacheBusAdr[OFFSET +: LINE_AW];
                    wr_d    = bus.CacheBusRW[0];
                    beat_d  = '0;
                    wait_d  = WAIT_LOAD;
                    state_d = (LATENCY > 0) ? S_WAIT : S_BEAT;
                end
            end
            S_WAIT: begin
                if (bus.CacheBusRW == 2'b00) begin
                    state_d = S_IDLE;
                end else if (wait_q == '0) begin
                    state_d = S_BEAT;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_BEAT: begin
                sel    = wr_q;
                mem_we = wr_q;
                if (!wr_q) begin
                    fb_d[int'(beat_q) * BEATLEN +: BEATLEN] = mem_rdata;
                end
                // Wraps to zero on the last beat, so ACK already shows beat 0.
                beat_d = beat_q + 1'b1;
                if (beat_q == '1) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                ack     = 1'b1;
                sel     = wr_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            wr_q    <= 1'b0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            wr_q    <= wr_d;
            fb_q    <= fb_d;
        end
    end

    // Store is not reset: a beat in flight when reset arrives still lands.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= bus.CacheWriteBeat;
        end
    end

    assign bus.FetchBuffer = fb_q;
    assign bus.BeatCount   = beat_q;
    assign bus.SelBusBeat  = sel;
    assign bus.CacheBusAck = ack;
    assign bus.BusBusy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_cachelinemem.sv
// Bench for cachelinemem: two instances (LATENCY 2 and 0) checked every cycle
// against a transaction-level model of bus timing and backing-store contents.
module tb_cachelinemem;
    localparam int MEMBEATS = 4096;
    localparam int NB       = 8;
    localparam int LAT0     = 2;
    localparam int LAT1     = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_in [2];
    logic [1:0]   rw_in  [2];
    logic [33:0]  adr_in [2];
    logic [63:0]  wb_in  [2];

    logic         act_busy [2];
    logic         act_ack  [2];
    logic         act_sel  [2];
    logic [2:0]   act_bc   [2];
    logic [511:0] act_fb   [2];

    logic         exp_busy [2];
    logic         exp_ack  [2];
    logic         exp_sel  [2];
    logic [2:0]   exp_bc   [2];
    logic [511:0] exp_fb   [2];

    logic [63:0]  mem_m [2][MEMBEATS];
    logic [63:0]  wbuf  [NB];

    int  errors = 0;
    int  checks = 0;
    bit  chk_en = 1'b0;
    int  last_ack [2];
    int  prev_ack [2];
    int  ack_cnt  [2];

    cachelinemem_if #(.PA_BITS(34), .LINELEN(512), .BEATLEN(64), .LOGBWPL(3)) bus0();
    cachelinemem_if #(.PA_BITS(34), .LINELEN(512), .BEATLEN(64), .LOGBWPL(3)) bus1();

    cachelinemem #(.PA_BITS(34), .LINELEN(512), .BEATLEN(64), .LOGBWPL(3),
                   .MEMBEATS(MEMBEATS), .LATENCY(LAT0))
        dut0 (.clk(clk), .reset(rst_in[0]), .bus(bus0));
    cachelinemem #(.PA_BITS(34), .LINELEN(512), .BEATLEN(64), .LOGBWPL(3),
                   .MEMBEATS(MEMBEATS), .LATENCY(LAT1))
        dut1 (.clk(clk), .reset(rst_in[1]), .bus(bus1));

    assign bus0.CacheBusRW     = rw_in[0];
    assign bus0.CacheBusAdr    = adr_in[0];
    assign bus0.CacheWriteBeat = wb_in[0];
    assign bus1.CacheBusRW     = rw_in[1];
    assign bus1.CacheBusAdr    = adr_in[1];
    assign bus1.CacheWriteBeat = wb_in[1];

    assign act_busy[0] = bus0.BusBusy;
    assign act_ack[0]  = bus0.CacheBusAck;
    assign act_sel[0]  = bus0.SelBusBeat;
    assign act_bc[0]   = bus0.BeatCount;
    assign act_fb[0]   = bus0.FetchBuffer;
    assign act_busy[1] = bus1.BusBusy;
    assign act_ack[1]  = bus1.CacheBusAck;
    assign act_sel[1]  = bus1.SelBusBeat;
    assign act_bc[1]   = bus1.BeatCount;
    assign act_fb[1]   = bus1.FetchBuffer;

    task automatic chk(input string name, input int d, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("busy", d, 512'(act_busy[d]), 512'(exp_busy[d]));
                chk("ack",  d, 512'(act_ack[d]),  512'(exp_ack[d]));
                chk("sel",  d, 512'(act_sel[d]),  512'(exp_sel[d]));
                chk("beat", d, 512'(act_bc[d]),   512'(exp_bc[d]));
                chk("fetchbuf", d, act_fb[d], exp_fb[d]);
                if (act_ack[d]) begin
                    prev_ack[d] = last_ack[d];
                    last_ack[d] = cyc;
                    ack_cnt[d]++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle(input int d);
        exp_busy[d] = 1'b0;
        exp_ack[d]  = 1'b0;
        exp_sel[d]  = 1'b0;
        exp_bc[d]   = 3'd0;
    endtask

    // Runs one request starting in the current (idle) cycle, k = 0.
    // Request timeline: WAIT k=1..lat, beat b at k=lat+1+b, ack at k=lat+NB+1.
    // abort_k drops RW in that WAIT cycle; rst_k asserts reset in that cycle.
    task automatic do_req(input int d, input logic [1:0] rw, input logic [33:0] adr,
                          input int abort_k, input int rst_k, input logic [1:0] rw_after);
        int lat, base, last;
        bit wr;
        lat  = (d == 0) ? LAT0 : LAT1;
        last = lat + NB + 1;
        base = int'((adr / 64) % (MEMBEATS / NB)) * NB;
        wr   = rw[0];
        rw_in[d]  = rw;
        adr_in[d] = adr;
        for (int k = 1; k <= last + 1; k++) begin
            step();
            if (k - 1 > lat && k - 1 <= lat + NB) begin
                int b;
                b = k - 2 - lat;
                if (wr) mem_m[d][base + b] = wbuf[b];
                else    exp_fb[d][b*64 +: 64] = mem_m[d][base + b];
            end
            if (k - 1 == rst_k) begin
                rst_in[d] = 1'b0;
                exp_fb[d] = '0;
                set_idle(d);
                return;
            end
            if (k - 1 == abort_k) begin
                set_idle(d);
                return;
            end
            if (k == last + 1) begin
                set_idle(d);
                rw_in[d] = rw_after;
                wb_in[d] = '0;
                return;
            end
            exp_busy[d] = 1'b1;
            exp_ack[d]  = (k == last);
            exp_sel[d]  = wr && (k > lat);
            exp_bc[d]   = (k > lat && k < last) ? 3'(k - lat - 1) : 3'd0;
            wb_in[d]    = (wr && k > lat && k < last) ? wbuf[k - lat - 1] : 64'd0;
            if (k == abort_k) rw_in[d] = 2'b00;
            if (k == rst_k) begin
                rst_in[d] = 1'b1;
                rw_in[d]  = 2'b00;
            end
        end
    endtask

    task automatic fill_wbuf(input logic [63:0] pattern);
        for (int b = 0; b < NB; b++) wbuf[b] = pattern + 64'(b);
    endtask

    task automatic fill_rand();
        for (int b = 0; b < NB; b++) wbuf[b] = {$urandom, $urandom};
    endtask

    localparam logic [33:0] ADR_L  = 34'h0_8000_0040;
    localparam logic [33:0] ADR_A  = 34'h0_9000_1000;
    localparam logic [33:0] ADR_C  = 34'h0_8000_2fc0;
    localparam logic [33:0] ADR_D  = 34'h1_2345_6780;

    initial begin
        int t0, n0;
        logic [33:0] pool [4];
        for (int d = 0; d < 2; d++) begin
            rst_in[d] = 1'b1;
            rw_in[d]  = 2'b00;
            adr_in[d] = '0;
            wb_in[d]  = '0;
            exp_fb[d] = '0;
            last_ack[d] = 0;
            prev_ack[d] = 0;
            ack_cnt[d]  = 0;
            set_idle(d);
        end
        step();
        step();
        rst_in[0] = 1'b0;
        rst_in[1] = 1'b0;
        chk_en = 1'b1;
        step();

        // Writeback of a patterned line.
        fill_wbuf(64'h1111_0000_0000_0000);
        t0 = cyc;
        n0 = ack_cnt[0];
        do_req(0, 2'b01, ADR_L, -1, -1, 2'b00);
        chk("wb_ack_cycle", 0, 512'(last_ack[0] - t0), 512'(11));
        chk("wb_ack_count", 0, 512'(ack_cnt[0] - n0), 512'(1));

        // Fetch it back.
        t0 = cyc;
        do_req(0, 2'b10, ADR_L, -1, -1, 2'b00);
        chk("rd_ack_cycle", 0, 512'(last_ack[0] - t0), 512'(11));
        for (int i = 0; i < NB; i++)
            chk("rd_beat_lit", 0, 512'(act_fb[0][i*64 +: 64]), 512'(64'h1111_0000_0000_0000 + 64'(i)));

        // Cancelled fetch, then a normal fetch.
        n0 = ack_cnt[0];
        do_req(0, 2'b10, ADR_L, 2, -1, 2'b00);
        step();
        chk("abort_no_ack", 0, 512'(ack_cnt[0] - n0), 512'(0));
        do_req(0, 2'b10, ADR_L, -1, -1, 2'b00);

        // Writeback A then fetch of another line with no dead cycle between.
        fill_rand();
        do_req(0, 2'b01, ADR_A, -1, -1, 2'b10);
        do_req(0, 2'b10, ADR_L, -1, -1, 2'b00);
        chk("b2b_ack_gap", 0, 512'(last_ack[0] - prev_ack[0]), 512'(12));
        do_req(0, 2'b10, ADR_A, -1, -1, 2'b00);

        // Zero-latency instance, plus an aliased address.
        fill_rand();
        do_req(1, 2'b11, ADR_D, -1, -1, 2'b00);
        t0 = cyc;
        do_req(1, 2'b10, ADR_D, -1, -1, 2'b00);
        chk("lat0_ack_cycle", 1, 512'(last_ack[1] - t0), 512'(9));
        do_req(1, 2'b10, ADR_D + 34'(MEMBEATS * 8), -1, -1, 2'b00);

        // Reset during beat 3 of a writeback over known old data.
        fill_wbuf(64'hAAAA_0000_0000_0000);
        do_req(0, 2'b01, ADR_C, -1, -1, 2'b00);
        fill_wbuf(64'hBBBB_0000_0000_0000);
        n0 = ack_cnt[0];
        do_req(0, 2'b01, ADR_C, -1, LAT0 + 1 + 3, 2'b00);
        step();
        chk("rst_no_ack", 0, 512'(ack_cnt[0] - n0), 512'(0));
        do_req(0, 2'b10, ADR_C, -1, -1, 2'b00);
        chk("rst_beat3_new", 0, 512'(act_fb[0][3*64 +: 64]), 512'(64'hBBBB_0000_0000_0003));
        chk("rst_beat4_old", 0, 512'(act_fb[0][4*64 +: 64]), 512'(64'hAAAA_0000_0000_0004));

        // Randomized traffic over a small pool of lines on both instances.
        for (int p = 0; p < 4; p++) begin
            pool[p] = {$urandom_range(0, 3), $urandom} & ~34'h3f;
            for (int d = 0; d < 2; d++) begin
                fill_rand();
                do_req(d, 2'b01, pool[p], -1, -1, 2'b00);
            end
        end
        for (int it = 0; it < 40; it++) begin
            int d, ab;
            logic [33:0] a;
            logic [1:0] rw;
            d  = int'($urandom_range(0, 1));
            a  = pool[$urandom_range(0, 3)] + 34'($urandom_range(0, 63))
                 + 34'(MEMBEATS * 8) * 34'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       rw = 2'b01;
                1:       rw = 2'b11;
                default: rw = 2'b10;
            endcase
            ab = (d == 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT0)) : -1;
            fill_rand();
            do_req(d, rw, a, ab, -1, 2'b00);
            if (ab > 0 || $urandom_range(0, 1) == 1) step();
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
